// File: rtl/lcd_spi_sequencer_if.sv
// Byte-fetch handshake between the LCD sequencer (master) and the cipher encoder (slave).
interface lcd_spi_sequencer_if #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned KEY_W  = 3
);
    logic              data_req;
    logic [ADDR_W-1:0] ram_addr;
    logic [KEY_W-1:0]  key_sel;
    logic [7:0]        data_in;
    logic              data_ack;

    modport master (
        output data_req, ram_addr, key_sel,
        input  data_in, data_ack
    );

    modport slave (
        input  data_req, ram_addr, key_sel,
        output data_in, data_ack
    );
endinterface

// File: rtl/lcd_spi_sequencer.sv
// PCD8544 (Nokia 5110) sequencer: LCD reset, init command list, then endless streaming of
// encoded character columns over an on-chip SPI mode 0 serialiser paced by a tick divider.
module lcd_spi_sequencer #(
    parameter int unsigned CLK_DIV     = 2048,
    parameter int unsigned RST_TICKS   = 4,
    parameter int unsigned ADDR_W      = 4,
    parameter int unsigned RAM_DEPTH   = 16,
    parameter int unsigned KEY_W       = 3,
    parameter int unsigned NUM_KEYS    = 6,
    parameter int unsigned FRAME_CHARS = 84,
    parameter logic [7:0]  VOP         = 8'hB0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                run,
    lcd_spi_sequencer_if.master enc,
    output logic                lcd_rst_n,
    output logic                lcd_ce_n,
    output logic                lcd_dc,
    output logic                lcd_sclk,
    output logic                lcd_sdin,
    output logic                busy,
    output logic                frame_done
);
    localparam int unsigned DivW     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned LastTick = 17;
    localparam int unsigned TickMax  = (RST_TICKS > LastTick) ? RST_TICKS : LastTick;
    localparam int unsigned TW       = $clog2(TickMax + 1);
    localparam int unsigned PosW     = (FRAME_CHARS > 1) ? $clog2(FRAME_CHARS) : 1;

    typedef enum logic [2:0] {StHold, StInit, StFetch, StSend, StAdvance, StIdle} state_e;

    state_e          state_q, state_d;
    logic [DivW-1:0] div_q, div_d;
    logic [TW-1:0]   tcnt_q, tcnt_d;
    logic [2:0]      idx_q, idx_d;
    logic [PosW-1:0] pos_q, pos_d;
    logic [KEY_W-1:0] key_q, key_d;
    logic [7:0]      byte_q, byte_d;
    logic [7:0]      sh_q, sh_d;
    logic            busy_q, busy_d;
    logic            rst_n_q, rst_n_d;
    logic            ce_n_q, ce_n_d;
    logic            dc_q, dc_d;
    logic            sclk_q, sclk_d;
    logic            sdin_q, sdin_d;
    logic            tick;
    logic            byte_end;
    logic [7:0]      cur_byte;

    function automatic logic [7:0] init_byte(input logic [2:0] idx);
        case (idx)
            3'd0:    init_byte = 8'h21;
            3'd1:    init_byte = VOP;
            3'd2:    init_byte = 8'h04;
            3'd3:    init_byte = 8'h14;
            3'd4:    init_byte = 8'h20;
            default: init_byte = 8'h0C;
        endcase
    endfunction

    assign tick     = (div_q == DivW'(CLK_DIV - 1));
    assign cur_byte = (state_q == StInit) ? init_byte(idx_q) : byte_q;

    always_comb begin
        state_d  = state_q;
        div_d    = tick ? '0 : div_q + DivW'(1);
        tcnt_d   = tcnt_q;
        idx_d    = idx_q;
        pos_d    = pos_q;
        key_d    = key_q;
        byte_d   = byte_q;
        sh_d     = sh_q;
        busy_d   = busy_q;
        rst_n_d  = rst_n_q;
        ce_n_d   = ce_n_q;
        dc_d     = dc_q;
        sclk_d   = sclk_q;
        sdin_d   = sdin_q;
        byte_end = 1'b0;

        case (state_q)
            StHold: begin
                if (tick) begin
                    if (tcnt_q == TW'(RST_TICKS - 1)) begin
                        tcnt_d  = '0;
                        rst_n_d = 1'b1;
                        state_d = StInit;
                    end else begin
                        tcnt_d = tcnt_q + TW'(1);
                    end
                end
            end
            StInit, StSend: begin
                // t0 frames the byte, odd ticks raise sclk, even ticks drop it and shift
                if (tick) begin
                    tcnt_d = tcnt_q + TW'(1);
                    if (tcnt_q == '0) begin
                        ce_n_d = 1'b0;
                        dc_d   = (state_q == StSend);
                        sh_d   = cur_byte;
                        sdin_d = cur_byte[7];
                    end else if (tcnt_q == TW'(LastTick)) begin
                        ce_n_d   = 1'b1;
                        tcnt_d   = '0;
                        byte_end = 1'b1;
                    end else if (tcnt_q[0]) begin
                        sclk_d = 1'b1;
                    end else begin
                        sclk_d = 1'b0;
                        if (tcnt_q != TW'(LastTick - 1)) begin
                            sh_d   = {sh_q[6:0], 1'b0};
                            sdin_d = sh_q[6];
                        end
                    end
                end
                if (byte_end) begin
                    if (state_q == StInit) begin
                        if (idx_q == 3'd5) begin
                            idx_d   = '0;
                            busy_d  = 1'b0;
                            state_d = StFetch;
                        end else begin
                            idx_d = idx_q + 3'd1;
                        end
                    end else if (key_q == KEY_W'(NUM_KEYS - 1)) begin
                        key_d   = '0;
                        state_d = StAdvance;
                    end else begin
                        key_d   = key_q + KEY_W'(1);
                        state_d = StFetch;
                    end
                end
            end
            StFetch: begin
                if (enc.data_ack) begin
                    byte_d  = enc.data_in;
                    state_d = StSend;
                end
            end
            StAdvance: begin
                pos_d   = (pos_q == PosW'(FRAME_CHARS - 1)) ? '0 : pos_q + PosW'(1);
                state_d = run ? StFetch : StIdle;
            end
            StIdle: begin
                if (run) state_d = StFetch;
            end
            default: state_d = StHold;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StHold;
            div_q   <= '0;
            tcnt_q  <= '0;
            idx_q   <= '0;
            pos_q   <= '0;
            key_q   <= '0;
            byte_q  <= '0;
            sh_q    <= '0;
            busy_q  <= 1'b1;
            rst_n_q <= 1'b0;
            ce_n_q  <= 1'b1;
            dc_q    <= 1'b0;
            sclk_q  <= 1'b0;
            sdin_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            tcnt_q  <= tcnt_d;
            idx_q   <= idx_d;
            pos_q   <= pos_d;
            key_q   <= key_d;
            byte_q  <= byte_d;
            sh_q    <= sh_d;
            busy_q  <= busy_d;
            rst_n_q <= rst_n_d;
            ce_n_q  <= ce_n_d;
            dc_q    <= dc_d;
            sclk_q  <= sclk_d;
            sdin_q  <= sdin_d;
        end
    end

    // Characters beyond the RAM contents all map to the trailing fill entry
    assign enc.ram_addr = (32'(pos_q) >= RAM_DEPTH - 1) ? ADDR_W'(RAM_DEPTH - 1)
                                                         : ADDR_W'(pos_q);
    assign enc.key_sel  = key_q;
    assign enc.data_req = (state_q == StFetch);

    assign lcd_rst_n  = rst_n_q;
    assign lcd_ce_n   = ce_n_q;
    assign lcd_dc     = dc_q;
    assign lcd_sclk   = sclk_q;
    assign lcd_sdin   = sdin_q;
    assign busy       = busy_q;
    assign frame_done = (state_q == StAdvance) && (pos_q == PosW'(FRAME_CHARS - 1));
endmodule

// File: tb/tb_lcd_spi_sequencer.sv
// Bench for lcd_spi_sequencer: SPI decoder + character-level fetch model checked every clock,
// driven through directed scenarios (init, first character, full frame, stalls, run, reset).
module tb_lcd_spi_sequencer;
    localparam int CLK_DIV     = 2;
    localparam int RST_TICKS   = 4;
    localparam int RAM_DEPTH   = 16;
    localparam int NUM_KEYS    = 6;
    localparam int FRAME_CHARS = 84;
    localparam int FRAME_BYTES = NUM_KEYS * FRAME_CHARS;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    logic run   = 1'b0;
    logic lcd_rst_n, lcd_ce_n, lcd_dc, lcd_sclk, lcd_sdin, busy, frame_done;

    lcd_spi_sequencer_if #(.ADDR_W(4), .KEY_W(3)) bus ();

    lcd_spi_sequencer #(
        .CLK_DIV(CLK_DIV), .RST_TICKS(RST_TICKS), .ADDR_W(4), .RAM_DEPTH(RAM_DEPTH),
        .KEY_W(3), .NUM_KEYS(NUM_KEYS), .FRAME_CHARS(FRAME_CHARS), .VOP(8'hB0)
    ) dut (
        .clk(clk), .reset(reset), .run(run), .enc(bus),
        .lcd_rst_n(lcd_rst_n), .lcd_ce_n(lcd_ce_n), .lcd_dc(lcd_dc), .lcd_sclk(lcd_sclk),
        .lcd_sdin(lcd_sdin), .busy(busy), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int n_asserts = 0;
    int n_fail    = 0;
    int edges     = 0;
    int ack_delay = 0;
    bit spurious  = 1'b0;
    int exp_q[$];
    int exp_pos, exp_key;
    int data_cnt, cmd_cnt, frame_cnt, frame_at, nbits;
    int init_log[6];
    int data_log[6];
    int init_tbl[6]   = '{8'h21, 8'hB0, 8'h04, 8'h14, 8'h20, 8'h0C};
    int first_chr[6]  = '{8'h55, 8'h54, 8'h57, 8'h56, 8'h51, 8'h50};

    task automatic check(input string name, input int act, input int exp);
        n_asserts++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_reset_outputs();
        check("rst_lcd_rst_n", lcd_rst_n, 0);
        check("rst_lcd_ce_n", lcd_ce_n, 1);
        check("rst_lcd_dc", lcd_dc, 0);
        check("rst_lcd_sclk", lcd_sclk, 0);
        check("rst_lcd_sdin", lcd_sdin, 0);
        check("rst_busy", busy, 1);
        check("rst_frame_done", frame_done, 0);
        check("rst_data_req", bus.data_req, 0);
        check("rst_ram_addr", bus.ram_addr, 0);
        check("rst_key_sel", bus.key_sel, 0);
    endtask

    task automatic push_init();
        exp_q.delete();
        for (int i = 0; i < 6; i++) exp_q.push_back(init_tbl[i]);
    endtask

    function automatic int enc_byte(input int addr, input int key);
        return ((addr << 4) | key) ^ 8'h55;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) edges <= 0;
        else        edges <= edges + 1;
    end

    // Encoder stand-in plus the character-level fetch model (pos, key) it checks against
    initial begin : encoder
        int req_cnt;
        int hold_addr, hold_key;
        req_cnt = 0;
        bus.data_ack = 1'b0;
        bus.data_in  = 8'h00;
        forever begin
            @(negedge clk);
            if (!reset) begin
                req_cnt = 0;
                exp_pos = 0;
                exp_key = 0;
                bus.data_ack = 1'b0;
            end else if (bus.data_req) begin
                if (req_cnt == 0) begin
                    hold_addr = bus.ram_addr;
                    hold_key  = bus.key_sel;
                    check("req_addr", bus.ram_addr,
                          (exp_pos < RAM_DEPTH - 1) ? exp_pos : RAM_DEPTH - 1);
                    check("req_key", bus.key_sel, exp_key);
                end else begin
                    check("req_addr_stable", bus.ram_addr, hold_addr);
                    check("req_key_stable", bus.key_sel, hold_key);
                end
                check("req_sclk_low", lcd_sclk, 0);
                check("req_ce_n_high", lcd_ce_n, 1);
                if (req_cnt >= ack_delay) begin
                    bus.data_ack = 1'b1;
                    bus.data_in  = 8'(enc_byte(bus.ram_addr, bus.key_sel));
                    exp_q.push_back(256 | int'(bus.data_in));
                    exp_key++;
                    if (exp_key == NUM_KEYS) begin
                        exp_key = 0;
                        exp_pos = (exp_pos + 1) % FRAME_CHARS;
                    end
                end else begin
                    bus.data_ack = 1'b0;
                end
                req_cnt++;
            end else begin
                req_cnt = 0;
                bus.data_ack = spurious;
                bus.data_in  = 8'hFF;
            end
        end
    end

    // SPI decoder and pin-timing checks
    initial begin : monitor
        logic [4:0] pins, prev_pins;
        logic [7:0] sh_in;
        bit prev_busy, prev_fd, dc_byte;
        prev_pins = 5'b01000;
        sh_in = 8'h00;
        forever begin
            @(negedge clk);
            if (!reset) begin
                nbits = 0;
                prev_pins = 5'b01000;
                prev_busy = 1'b1;
                prev_fd = 1'b0;
                cmd_cnt = 0;
                data_cnt = 0;
                frame_cnt = 0;
            end else begin
                pins = {lcd_rst_n, lcd_ce_n, lcd_dc, lcd_sclk, lcd_sdin};
                if (pins != prev_pins) check("pin_change_on_tick", edges % CLK_DIV, 0);
                if (lcd_rst_n && !prev_pins[4])
                    check("rst_low_clks", edges, RST_TICKS * CLK_DIV);
                if (!lcd_ce_n && prev_pins[3]) begin
                    nbits = 0;
                    dc_byte = lcd_dc;
                end
                if (!lcd_ce_n) check("dc_stable", lcd_dc, dc_byte);
                if (!lcd_ce_n && lcd_sclk && !prev_pins[1]) begin
                    sh_in = {sh_in[6:0], lcd_sdin};
                    nbits++;
                end
                if (lcd_ce_n && !prev_pins[3]) begin
                    check("bits_per_byte", nbits, 8);
                    check("byte_expected", int'(exp_q.size() != 0), 1);
                    if (exp_q.size() != 0)
                        check("spi_byte", (int'(dc_byte) << 8) | int'(sh_in), exp_q.pop_front());
                    if (dc_byte) begin
                        if (data_cnt < 6) data_log[data_cnt] = sh_in;
                        data_cnt++;
                    end else begin
                        if (cmd_cnt < 6) init_log[cmd_cnt] = sh_in;
                        cmd_cnt++;
                        if (cmd_cnt < 6) check("busy_during_init", busy, 1);
                    end
                end
                if (prev_busy && !busy) check("busy_fall_after_init", cmd_cnt, 6);
                if (frame_done) begin
                    frame_cnt++;
                    frame_at = data_cnt;
                    check("frame_done_pulse", prev_fd, 0);
                    check("frame_bytes_mod", data_cnt % FRAME_BYTES, 0);
                    check("frame_bytes_nonzero", int'(data_cnt != 0), 1);
                end
                prev_pins = pins;
                prev_busy = busy;
                prev_fd = frame_done;
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int held, pos_drop;
        bit idle_req;
        repeat (3) @(negedge clk);
        check_reset_outputs();
        push_init();
        reset = 1'b1;

        // run stays low: init must still complete and reach the first fetch
        for (int n = 0; n < 2000 && busy; n++) @(negedge clk);
        check("init_done", busy, 0);
        for (int i = 0; i < 6; i++) check("init_cmd", init_log[i], init_tbl[i]);
        run = 1'b1;

        for (int n = 0; n < 1000 && data_cnt < 6; n++) @(negedge clk);
        check("first_char_bytes", int'(data_cnt >= 6), 1);
        for (int i = 0; i < 6; i++) check("first_char", data_log[i], first_chr[i]);

        for (int n = 0; n < 30000 && frame_cnt < 1; n++) @(negedge clk);
        check("frame_cnt", frame_cnt, 1);
        check("frame_at", frame_at, 504);
        for (int n = 0; n < 200 && !bus.data_req; n++) @(negedge clk);
        check("wrap_req", bus.data_req, 1);
        check("wrap_addr", bus.ram_addr, 0);
        check("wrap_key", bus.key_sel, 0);
        for (int n = 0; n < 10 && bus.data_req; n++) @(negedge clk);

        // 37 clks without ack plus the clk carrying the ack
        ack_delay = 37;
        for (int n = 0; n < 200 && !bus.data_req; n++) @(negedge clk);
        held = 0;
        while (bus.data_req && held < 300) begin
            held++;
            @(negedge clk);
        end
        check("delayed_req_clks", held, 38);
        ack_delay = 0;

        for (int n = 0; n < 1000 && !(bus.data_req && bus.key_sel == 2); n++) @(negedge clk);
        check("drop_at_key2", bus.key_sel, 2);
        pos_drop = bus.ram_addr;
        run = 1'b0;
        for (int n = 0; n < 1000 && !(bus.data_req && bus.key_sel == 5); n++) @(negedge clk);
        for (int n = 0; n < 10 && bus.data_req; n++) @(negedge clk);
        repeat (60) @(negedge clk);
        spurious = 1'b1;
        idle_req = 1'b0;
        repeat (80) begin
            @(negedge clk);
            if (bus.data_req) idle_req = 1'b1;
        end
        check("idle_no_req", idle_req, 0);
        check("idle_ce_n", lcd_ce_n, 1);
        check("idle_data_cnt", data_cnt, 510);
        check("idle_queue_empty", exp_q.size(), 0);
        spurious = 1'b0;
        repeat (2) @(negedge clk);
        run = 1'b1;
        for (int n = 0; n < 100 && !bus.data_req; n++) @(negedge clk);
        check("resume_addr", bus.ram_addr, pos_drop + 1);
        check("resume_key", bus.key_sel, 0);

        for (int n = 0; n < 300 && !(!lcd_ce_n && lcd_dc && nbits == 4); n++) @(negedge clk);
        check("midbyte_reached", nbits, 4);
        reset = 1'b0;
        #1;
        check_reset_outputs();
        exp_q.delete();
        repeat (3) @(negedge clk);
        push_init();
        reset = 1'b1;
        for (int n = 0; n < 2000 && busy; n++) @(negedge clk);
        check("reinit_done", busy, 0);
        check("reinit_cmd_cnt", cmd_cnt, 6);
        for (int i = 0; i < 6; i++) check("reinit_cmd", init_log[i], init_tbl[i]);
        repeat (20) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end
endmodule

// File: doc/lcd_spi_sequencer.md
Name: lcd_spi_sequencer

Overview:
- Parametrised successor to the Nokia 5110 (PCD8544) LCD driver in the XOR-cipher design.
- Emits the LCD init command list, then streams encoded character columns forever.
- Serialises bytes on-chip as SPI mode 0, so no separate serializer is needed.
- Runs on a single clock with a tick-enable divider, not a derived clock.
- Fetches cipher bytes through a req/ack handshake with the encoder.

Parameters:
- CLK_DIV, 2048: system clocks per tick; SCLK half-period = 1 tick; must be >= 2.
- RST_TICKS, 4: ticks lcd_rst_n is held low after reset release.
- ADDR_W, 4: RAM read-address width.
- RAM_DEPTH, 16: valid RAM entries; the last entry is the blank/fill character.
- KEY_W, 3: encoder key-select width.
- NUM_KEYS, 6: columns (bytes) per character; must be <= 2**KEY_W.
- FRAME_CHARS, 84: characters per frame (84 x 6 bytes = 504 = full 84x48 display).
- VOP, 8'hB0: contrast command byte.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous active-low reset.
- run  in  1  streaming enable; sampled at character boundaries.
- data_in  in  8  encoder output byte.
- data_ack  in  1  data_in is valid this cycle.
- data_req  out  1  request for the byte at ram_addr/key_sel.
- ram_addr  out  ADDR_W  RAM read address.
- key_sel  out  KEY_W  encoder key/column select.
- lcd_rst_n  out  1  LCD reset.
- lcd_ce_n  out  1  LCD chip enable.
- lcd_dc  out  1  0 = command, 1 = data.
- lcd_sclk  out  1  SPI clock.
- lcd_sdin  out  1  SPI data, MSB first.
- busy  out  1  high from reset release until init completes.
- frame_done  out  1  one-clk pulse when the last byte of a frame finishes.

Behaviour:
- Reset (async, reset=0): all outputs 0, except lcd_ce_n=1 and busy=1. All state returns to HOLD. Reset mid-byte aborts the byte immediately.
- Divider: counts 0..CLK_DIV-1; tick = one-clk pulse at wrap. All LCD-pin changes occur only on tick.
- Byte transfer, 18 ticks:
  - t0: lcd_ce_n=0, lcd_dc valid, lcd_sdin=bit7.
  - Odd ticks: lcd_sclk rises.
  - Even ticks: lcd_sclk falls and the next bit is driven.
  - After the 8th fall: lcd_ce_n=1 for one tick.
  - lcd_dc is stable for the whole byte.
- FSM states:
  - HOLD: lcd_rst_n=0 for RST_TICKS ticks, then lcd_rst_n=1 → INIT.
  - INIT: send the fixed table 21,VOP,04,14,20,0C with dc=0, in order; after the 6th byte busy=0 → FETCH.
  - FETCH: drive ram_addr and key_sel, assert data_req. On the first clk with data_ack=1, latch data_in and deassert data_req next clk → SEND. No timeout; data_req stays high indefinitely until ack. data_ack while data_req=0 is ignored.
  - SEND: transmit the latched byte with dc=1. On completion:
    - if key_sel < NUM_KEYS-1: key_sel+1 → FETCH;
    - else: key_sel=0 → ADVANCE.
  - ADVANCE (1 clk): pos = pos+1, wrapping to 0 after FRAME_CHARS-1; pulse frame_done on wrap; → FETCH if run=1, else IDLE.
  - IDLE: lcd_ce_n=1, outputs held; run=1 → FETCH at the next clk.
- Address rule: ram_addr = min(pos, RAM_DEPTH-1), so characters past the RAM contents show the fill character. pos is an internal counter sized ceil(log2(FRAME_CHARS)).
- run low during INIT is ignored; init always completes.
- run is not checked mid-character; a character always completes all NUM_KEYS bytes.
- frame_done coincides with ADVANCE and is independent of run.

Test Plan:
- Reset release, CLK_DIV=2:
  - lcd_rst_n low for 4 ticks (8 clks).
  - Six command bytes 21,B0,04,14,20,0C decoded from sdin on sclk rising edges with dc=0.
  - busy falls after the 6th byte.
- Immediate ack with data_in = key_sel XOR 8'h55:
  - first character sends 55,54,57,56,51,50 with dc=1;
  - key_sel steps 0..5; ram_addr=0.
- Full frame:
  - ram_addr sequence 0..15, then 15 held for pos 16..83;
  - 504 data bytes, then one frame_done pulse;
  - the next character is at ram_addr=0.
- Ack delayed 37 clks:
  - data_req held high with ram_addr/key_sel stable;
  - sclk stays low and ce_n stays high until ack.
- run dropped mid-character (key 2):
  - the remaining keys 3..5 are sent, then IDLE;
  - raising run resumes at the next pos with key 0.
- reset asserted at bit 4 of a data byte:
  - all outputs at reset values in the same clk (async);
  - after release, the init sequence restarts from 21.
